// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch mode sequencer and the display decoder:
// state encoding, blink field selects, and the post-clear/post-adjust resume rule.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ADJ   = 2'd3
  } state_t;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_SEC  = 2'b01;
  localparam logic [1:0] BLINK_MIN  = 2'b10;

  // Registered controller outputs, kept together so they update as one word.
  typedef struct packed {
    logic       sec_inc;
    logic       sec_carry_en;
    logic       min_inc;
    logic       time_clr;
    logic       running;
    logic [1:0] blink_sel;
  } ctrl_out_t;

  // Where the controller lands when leaving CLEAR or ADJ.
  function automatic state_t resume_state(input logic adj, input logic paused);
    if (adj)    return ST_ADJ;
    if (paused) return ST_PAUSE;
    return ST_RUN;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge.sv
// Rising-edge detector: one history register plus AND-NOT. With RESET_LOAD set,
// reset preloads the history with the live input so a held level is not an edge.
module edge_pulse #(
  parameter bit RESET_LOAD = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) prev <= RESET_LOAD ? din : 1'b0;
    else      prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust mode sequencer for the stopwatch: turns button edges and
// divider ticks into registered single-cycle counter strobes and blink selects.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter bit TICK_SYNC = 1'b1,
  parameter int MIN_MAX   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       onehz_clk,
  input  logic       twohz_clk,
  input  logic       sel,
  input  logic       adj,
  input  logic       pause,
  input  logic       clr,
  output logic       sec_inc,
  output logic       sec_carry_en,
  output logic       min_inc,
  output logic       time_clr,
  output logic       running,
  output logic [1:0] blink_sel
);

  // A build without a minutes field never adjusts or blinks minutes.
  localparam bit         HAS_MIN   = (MIN_MAX > 0);
  localparam logic [1:0] MIN_BLINK = HAS_MIN ? BLINK_MIN : BLINK_NONE;

  logic pause_edge, clr_edge, tick_1hz, tick_2hz;

  edge_pulse #(.RESET_LOAD(1'b1)) u_pause_edge (
    .clk(clk), .rst(rst), .din(pause), .pulse(pause_edge)
  );
  edge_pulse #(.RESET_LOAD(1'b1)) u_clr_edge (
    .clk(clk), .rst(rst), .din(clr), .pulse(clr_edge)
  );

  generate
    if (TICK_SYNC) begin : g_tick_sync
      edge_pulse #(.RESET_LOAD(1'b1)) u_1hz_edge (
        .clk(clk), .rst(rst), .din(onehz_clk), .pulse(tick_1hz)
      );
      edge_pulse #(.RESET_LOAD(1'b1)) u_2hz_edge (
        .clk(clk), .rst(rst), .din(twohz_clk), .pulse(tick_2hz)
      );
    end else begin : g_tick_pulse
      assign tick_1hz = onehz_clk;
      assign tick_2hz = twohz_clk;
    end
  endgenerate

  state_t    state, state_nxt;
  logic      paused, paused_nxt;
  ctrl_out_t out_q, out_nxt;

  // Priority: clr edge > adj level > pause edge > tick. A tick that loses is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt  = state;
    paused_nxt = paused;
    out_nxt    = '0;

    if (clr_edge) begin
      state_nxt        = ST_CLEAR;
      out_nxt.time_clr = 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Entered by a clr edge the pulse is already out; out of reset it is not.
          out_nxt.time_clr = ~out_q.time_clr;
          state_nxt        = resume_state(adj, paused);
        end
        ST_RUN: begin
          if (adj) begin
            state_nxt = ST_ADJ;
          end else if (pause_edge) begin
            paused_nxt = 1'b1;
            state_nxt  = ST_PAUSE;
          end else if (tick_1hz) begin
            out_nxt.sec_inc      = 1'b1;
            out_nxt.sec_carry_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (adj) begin
            state_nxt = ST_ADJ;
          end else if (pause_edge) begin
            paused_nxt = 1'b0;
            state_nxt  = ST_RUN;
          end
        end
        ST_ADJ: begin
          if (!adj) begin
            state_nxt = resume_state(1'b0, paused);
          end else if (pause_edge) begin
            paused_nxt = ~paused;
          end else if (tick_2hz) begin
            if (sel) out_nxt.sec_inc = 1'b1;
            else     out_nxt.min_inc = HAS_MIN;
          end
        end
        default: state_nxt = ST_CLEAR;
      endcase
    end

    out_nxt.running = (state_nxt == ST_RUN);
    if (state_nxt == ST_ADJ) out_nxt.blink_sel = sel ? BLINK_SEC : MIN_BLINK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_CLEAR;
      paused <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      paused <= paused_nxt;
      out_q  <= out_nxt;
    end
  end

  assign sec_inc      = out_q.sec_inc;
  assign sec_carry_en = out_q.sec_carry_en;
  assign min_inc      = out_q.min_inc;
  assign time_clr     = out_q.time_clr;
  assign running      = out_q.running;
  assign blink_sel    = out_q.blink_sel;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: per-cycle stimulus table with expected
// outputs, pushed to a scoreboard queue on drive and compared after each clk edge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst, onehz_clk, twohz_clk, sel, adj, pause, clr;
  logic       sec_inc, sec_carry_en, min_inc, time_clr, running;
  logic [1:0] blink_sel;

  stopwatch_ctrl #(.TICK_SYNC(1'b1), .MIN_MAX(59)) dut (
    .clk(clk), .rst(rst), .onehz_clk(onehz_clk), .twohz_clk(twohz_clk),
    .sel(sel), .adj(adj), .pause(pause), .clr(clr),
    .sec_inc(sec_inc), .sec_carry_en(sec_carry_en), .min_inc(min_inc),
    .time_clr(time_clr), .running(running), .blink_sel(blink_sel)
  );

  always #5 clk = ~clk;

  // Expected word: {sec_inc, sec_carry_en, min_inc, time_clr, running, blink_sel}
  localparam logic [6:0] O_IDLE     = 7'b0000000;
  localparam logic [6:0] O_RUN      = 7'b0000100;
  localparam logic [6:0] O_TICK     = 7'b1100100;
  localparam logic [6:0] O_TC       = 7'b0001000;
  localparam logic [6:0] O_CLR_RUN  = 7'b0001100;
  localparam logic [6:0] O_ADJ_MIN  = 7'b0000010;
  localparam logic [6:0] O_MINC     = 7'b0010010;
  localparam logic [6:0] O_ADJ_SEC  = 7'b0000001;
  localparam logic [6:0] O_SINC_ADJ = 7'b1000001;

  typedef struct {
    logic       r, o, t, s, a, p, c;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  typedef struct {
    logic [6:0] exp;
    string      tag;
    int         idx;
  } sb_t;

  vec_t  vecs[$];
  sb_t   exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  logic  r_v = 1'b0, o_v = 1'b0, t_v = 1'b0, s_v = 1'b0;
  logic  a_v = 1'b0, p_v = 1'b0, c_v = 1'b0;
  string tag_v = "reset";

  function automatic void add(input logic [6:0] e);
    vec_t v;
    v.r = r_v; v.o = o_v; v.t = t_v; v.s = s_v;
    v.a = a_v; v.p = p_v; v.c = c_v;
    v.exp = e; v.tag = tag_v;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %b required %b (si,ce,mi,tc,run,blink)",
               name, idx, got, exp);
    end
  endtask

  // Scoreboard side: each clk edge retires the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        sb_t e;
        e = exp_q.pop_front();
        check(e.tag, e.idx,
              {sec_inc, sec_carry_en, min_inc, time_clr, running, blink_sel},
              e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; onehz_clk = 1'b0; twohz_clk = 1'b0;
    sel = 1'b0; adj = 1'b0; pause = 1'b0; clr = 1'b0;

    // Reset with onehz moving, then five counted seconds.
    add(O_IDLE);
    o_v = 1; add(O_IDLE);
    tag_v = "release"; r_v = 1; add(O_CLR_RUN);
    tag_v = "run"; o_v = 0; add(O_RUN);
    for (int k = 0; k < 5; k++) begin
      o_v = 1; add(O_TICK); add(O_RUN);
      o_v = 0; add(O_RUN); add(O_RUN);
    end

    // Pause, three ignored seconds, resume.
    tag_v = "pause"; p_v = 1; add(O_IDLE); p_v = 0; add(O_IDLE);
    for (int k = 0; k < 3; k++) begin
      o_v = 1; add(O_IDLE); add(O_IDLE);
      o_v = 0; add(O_IDLE); add(O_IDLE);
    end
    tag_v = "resume"; p_v = 1; add(O_RUN); p_v = 0;
    o_v = 1; add(O_TICK); add(O_RUN); o_v = 0; add(O_RUN);

    // Adjust minutes (onehz rises alongside and must be ignored), then seconds.
    tag_v = "adj_min"; a_v = 1; add(O_ADJ_MIN);
    for (int k = 0; k < 4; k++) begin
      t_v = 1; o_v = 1; add(O_MINC);
      t_v = 0; o_v = 0; add(O_ADJ_MIN);
    end
    tag_v = "adj_sec"; s_v = 1; add(O_ADJ_SEC);
    for (int k = 0; k < 2; k++) begin
      t_v = 1; add(O_SINC_ADJ);
      t_v = 0; add(O_ADJ_SEC);
    end
    tag_v = "adj_exit"; a_v = 0; add(O_RUN);

    // Paused, enter adjust, toggle pause inside, leave: back to running.
    tag_v = "adj_toggle"; p_v = 1; add(O_IDLE); p_v = 0; add(O_IDLE);
    a_v = 1; add(O_ADJ_SEC);
    p_v = 1; add(O_ADJ_SEC); p_v = 0; add(O_ADJ_SEC);
    a_v = 0; add(O_RUN);
    o_v = 1; add(O_TICK); o_v = 0; add(O_RUN);

    // clr edge coinciding with a onehz rise in RUN: clear wins, tick dropped.
    tag_v = "clr_run"; c_v = 1; o_v = 1; add(O_TC);
    c_v = 0; add(O_RUN);
    o_v = 0; add(O_RUN);
    o_v = 1; add(O_TICK); o_v = 0; add(O_RUN);

    // clr while paused keeps the paused flag.
    tag_v = "clr_paused"; p_v = 1; add(O_IDLE); p_v = 0; add(O_IDLE);
    c_v = 1; add(O_TC); c_v = 0; add(O_IDLE);
    o_v = 1; add(O_IDLE);
    p_v = 1; o_v = 0; add(O_RUN); p_v = 0; add(O_RUN);

    // pause held across reset: no false edge, ends up running.
    tag_v = "rst_pause_held"; r_v = 0; p_v = 1; add(O_IDLE); add(O_IDLE);
    r_v = 1; add(O_CLR_RUN);
    add(O_RUN);
    p_v = 0; add(O_RUN);
    o_v = 1; add(O_TICK); o_v = 0; add(O_RUN);

    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      @(negedge clk);
      rst = vecs[i].r; onehz_clk = vecs[i].o; twohz_clk = vecs[i].t;
      sel = vecs[i].s; adj = vecs[i].a; pause = vecs[i].p; clr = vecs[i].c;
      e.exp = vecs[i].exp; e.tag = vecs[i].tag; e.idx = i;
      exp_q.push_back(e);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
